// File: rtl/tag_compare.sv
// -----------------------------------------------------------------------------
// tag_compare
//   Downstream stage of the tag FIFO. Pops one request at a time, pairs it with
//   the in-order tag-read response from the memory controller, decides hit or
//   miss, and presents the result on a valid/ready channel. Saturating hit and
//   miss counters track every decided request.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   fifo_aempty_i        tag FIFO has no entry to read
//   fifo_rden_o          tag FIFO read enable (single-cycle pulse)
//   fifo_data_i          {is_write, addr, tid}, valid the cycle after rden
//   rtag_i               {valid[55], dirty[54], stored_tag[53:0]}
//   rvalid_i / rready_o  tag response handshake
//   res_valid_o / res_ready_i  result handshake
//   res_hit_o, res_write_o, res_dirty_o, res_addr_o, res_tid_o,
//   res_victim_tag_o     registered result fields, stable while res_valid_o
//   stat_clr_i           synchronous clear of both counters (wins over inc)
//   hit_cnt_o, miss_cnt_o  saturating 32-bit counters
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | nothing in flight; read the FIFO as soon as it has an entry
// FETCH    | FIFO data valid this cycle; capture the request
// WAIT_TAG | waiting for the matching tag response (rready_o high)
// OUT      | result presented; hold until accepted, chain next FIFO read
// -----------------------------------------------------------------------------
module tag_compare #(
  parameter int ADDR_WIDTH   = 64,
  parameter int TID_WIDTH    = 16,
  parameter int INDEX_WIDTH  = 24,
  parameter int OFFSET_WIDTH = 6,
  // Tag width must not exceed the 54-bit stored tag field.
  parameter int TAG_W        = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            fifo_aempty_i,
  output logic                            fifo_rden_o,
  input  logic [ADDR_WIDTH+TID_WIDTH:0]   fifo_data_i,
  input  logic [55:0]                     rtag_i,
  input  logic                            rvalid_i,
  output logic                            rready_o,
  output logic                            res_valid_o,
  input  logic                            res_ready_i,
  output logic                            res_hit_o,
  output logic                            res_write_o,
  output logic                            res_dirty_o,
  output logic [ADDR_WIDTH-1:0]           res_addr_o,
  output logic [TID_WIDTH-1:0]            res_tid_o,
  output logic [TAG_W-1:0]                res_victim_tag_o,
  input  logic                            stat_clr_i,
  output logic [31:0]                     hit_cnt_o,
  output logic [31:0]                     miss_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    WAIT_TAG = 2'd2,
    OUT      = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Request captured from the FIFO entry.
  logic                  req_write_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [TID_WIDTH-1:0]  req_tid_q;

  // Result registers.
  logic                  res_hit_q;
  logic                  res_write_q;
  logic                  res_dirty_q;
  logic [ADDR_WIDTH-1:0] res_addr_q;
  logic [TID_WIDTH-1:0]  res_tid_q;
  logic [TAG_W-1:0]      res_victim_q;

  logic [31:0]           hit_cnt_q;
  logic [31:0]           miss_cnt_q;

  logic                  latch_req;
  logic                  take_rsp;

  logic [53:0]           req_tag;
  logic                  line_valid;
  logic                  hit_now;
  logic                  dirty_now;

  // Request tag sits above index+offset; zero-extend to the stored-tag width so
  // any stray high bits in the stored tag force a miss.
  assign req_tag    = 54'(req_addr_q[ADDR_WIDTH-1 -: TAG_W]);
  assign line_valid = rtag_i[55];
  assign hit_now    = line_valid && (rtag_i[53:0] == req_tag);
  assign dirty_now  = line_valid & rtag_i[54];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fifo_rden_o = 1'b0;
    rready_o    = 1'b0;
    res_valid_o = 1'b0;
    latch_req   = 1'b0;
    take_rsp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_aempty_i) begin
          fifo_rden_o = 1'b1;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        latch_req = 1'b1;
        state_d   = WAIT_TAG;
      end
      WAIT_TAG: begin
        rready_o = 1'b1;
        if (rvalid_i) begin
          take_rsp = 1'b1;
          state_d  = OUT;
        end
      end
      OUT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) begin
          // Chain the next read into the handshake cycle to keep 3-cycle throughput.
          if (!fifo_aempty_i) begin
            fifo_rden_o = 1'b1;
            state_d     = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_tid_q   <= '0;
    end else if (latch_req) begin
      req_write_q <= fifo_data_i[ADDR_WIDTH+TID_WIDTH];
      req_addr_q  <= fifo_data_i[ADDR_WIDTH+TID_WIDTH-1:TID_WIDTH];
      req_tid_q   <= fifo_data_i[TID_WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers, loaded only on the response-accept cycle so they stay
  // frozen for the whole OUT phase regardless of backpressure.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_hit_q    <= 1'b0;
      res_write_q  <= 1'b0;
      res_dirty_q  <= 1'b0;
      res_addr_q   <= '0;
      res_tid_q    <= '0;
      res_victim_q <= '0;
    end else if (take_rsp) begin
      res_hit_q    <= hit_now;
      res_write_q  <= req_write_q;
      res_dirty_q  <= dirty_now;
      res_addr_q   <= req_addr_q;
      res_tid_q    <= req_tid_q;
      res_victim_q <= rtag_i[TAG_W-1:0];
    end
  end

  assign res_hit_o        = res_hit_q;
  assign res_write_o      = res_write_q;
  assign res_dirty_o      = res_dirty_q;
  assign res_addr_o       = res_addr_q;
  assign res_tid_o        = res_tid_q;
  assign res_victim_tag_o = res_victim_q;

  // ---------------------------------------------------------------------------
  // Saturating statistics counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q <= '0;
    end else if (stat_clr_i) begin
      hit_cnt_q <= '0;
    end else if (take_rsp && hit_now && (hit_cnt_q != 32'hFFFF_FFFF)) begin
      hit_cnt_q <= hit_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt_q <= '0;
    end else if (stat_clr_i) begin
      miss_cnt_q <= '0;
    end else if (take_rsp && !hit_now && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_tag_compare.sv
// -----------------------------------------------------------------------------
// tb_tag_compare
//   Directed bench for tag_compare. Stimulus pushes FIFO entries, tag
//   responses and the hand-computed expected result into queues; a monitor
//   pops the expectation whenever a result handshake occurs and compares.
// -----------------------------------------------------------------------------
module tb_tag_compare;

  localparam int AW   = 64;
  localparam int TW   = 16;
  localparam int IW   = 24;
  localparam int OW   = 6;
  localparam int TAGW = AW - IW - OW;
  localparam int EW   = AW + TW + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            fifo_aempty_i = 1'b1;
  logic            fifo_rden_o;
  logic [EW-1:0]   fifo_data_i = '0;
  logic [55:0]     rtag_i = '0;
  logic            rvalid_i = 1'b0;
  logic            rready_o;
  logic            res_valid_o;
  logic            res_ready_i = 1'b1;
  logic            res_hit_o;
  logic            res_write_o;
  logic            res_dirty_o;
  logic [AW-1:0]   res_addr_o;
  logic [TW-1:0]   res_tid_o;
  logic [TAGW-1:0] res_victim_tag_o;
  logic            stat_clr_i = 1'b0;
  logic [31:0]     hit_cnt_o;
  logic [31:0]     miss_cnt_o;

  tag_compare #(
    .ADDR_WIDTH  (AW),
    .TID_WIDTH   (TW),
    .INDEX_WIDTH (IW),
    .OFFSET_WIDTH(OW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fifo_aempty_i   (fifo_aempty_i),
    .fifo_rden_o     (fifo_rden_o),
    .fifo_data_i     (fifo_data_i),
    .rtag_i          (rtag_i),
    .rvalid_i        (rvalid_i),
    .rready_o        (rready_o),
    .res_valid_o     (res_valid_o),
    .res_ready_i     (res_ready_i),
    .res_hit_o       (res_hit_o),
    .res_write_o     (res_write_o),
    .res_dirty_o     (res_dirty_o),
    .res_addr_o      (res_addr_o),
    .res_tid_o       (res_tid_o),
    .res_victim_tag_o(res_victim_tag_o),
    .stat_clr_i      (stat_clr_i),
    .hit_cnt_o       (hit_cnt_o),
    .miss_cnt_o      (miss_cnt_o)
  );

  typedef struct packed {
    logic            hit;
    logic            write;
    logic            dirty;
    logic [AW-1:0]   addr;
    logic [TW-1:0]   tid;
    logic [TAGW-1:0] victim;
  } exp_t;

  exp_t          sb_q[$];
  logic [EW-1:0] fifo_q[$];
  logic [55:0]   rsp_q[$];
  int            res_cyc_q[$];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int n_results  = 0;
  int last_rden_cyc  = 0;
  int valid_rise_cyc = 0;
  bit prev_valid = 1'b0;
  bit rsp_manual = 1'b0;
  bit rsp_taken  = 1'b0;
  bit pop_fifo   = 1'b0;
  logic [31:0] exp_hit_cnt  = '0;
  logic [31:0] exp_miss_cnt = '0;
  exp_t        mon_e;
  logic [55:0] rsp_dummy;

  localparam logic [AW-1:0] ADDR_A = 64'h0000_0040_1234_5680;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FIFO model: data appears the cycle after the read enable.
  initial forever begin
    @(negedge clk);
    pop_fifo = fifo_rden_o;
    if (fifo_rden_o) begin
      last_rden_cyc = cyc;
      check("rden_while_empty", 128'(fifo_aempty_i), 128'(0));
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (pop_fifo && fifo_q.size() > 0) fifo_data_i = fifo_q.pop_front();
    pop_fifo = 1'b0;
    fifo_aempty_i = (fifo_q.size() == 0);
  end

  // In-order tag response producer; holds each response until accepted.
  initial forever begin
    @(negedge clk);
    if (!rsp_manual && rvalid_i && rready_o) rsp_taken = 1'b1;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (!rsp_manual) begin
      if (rsp_taken && rsp_q.size() > 0) rsp_dummy = rsp_q.pop_front();
      rsp_taken = 1'b0;
      if (rsp_q.size() > 0) begin
        rvalid_i = 1'b1;
        rtag_i   = rsp_q[0];
      end else begin
        rvalid_i = 1'b0;
        rtag_i   = '0;
      end
    end
  end

  // Result monitor / scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n && res_valid_o && !prev_valid) valid_rise_cyc = cyc;
    prev_valid = rst_n && res_valid_o;
    if (rst_n && res_valid_o && res_ready_i) begin
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_result: got tid %0h expected no result", res_tid_o);
      end else begin
        mon_e = sb_q.pop_front();
        check("res_hit",    128'(res_hit_o),        128'(mon_e.hit));
        check("res_write",  128'(res_write_o),      128'(mon_e.write));
        check("res_dirty",  128'(res_dirty_o),      128'(mon_e.dirty));
        check("res_addr",   128'(res_addr_o),       128'(mon_e.addr));
        check("res_tid",    128'(res_tid_o),        128'(mon_e.tid));
        check("res_victim", 128'(res_victim_tag_o), 128'(mon_e.victim));
      end
      n_results++;
      res_cyc_q.push_back(cyc);
    end
  end

  task automatic push_fifo(input logic w, input logic [AW-1:0] a, input logic [TW-1:0] t);
    fifo_q.push_back({w, a, t});
    fifo_aempty_i = 1'b0;
  endtask

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [TW-1:0] t,
                       input logic [55:0] rt, input logic eh, input logic ed,
                       input logic [TAGW-1:0] vt);
    exp_t e;
    e.hit = eh; e.write = w; e.dirty = ed; e.addr = a; e.tid = t; e.victim = vt;
    sb_q.push_back(e);
    push_fifo(w, a, t);
    if (!rsp_manual) rsp_q.push_back(rt);
    if (eh) begin
      if (exp_hit_cnt != 32'hFFFF_FFFF) exp_hit_cnt = exp_hit_cnt + 32'd1;
    end else begin
      if (exp_miss_cnt != 32'hFFFF_FFFF) exp_miss_cnt = exp_miss_cnt + 32'd1;
    end
  endtask

  task automatic wait_results(input int target, input string name);
    int n = 0;
    while (n_results < target && n < 60) begin tick(); n++; end
    if (n_results < target) begin
      compared++;
      mismatched++;
      $display("FAIL %s: got %0d results expected %0d (timeout)", name, n_results, target);
    end
  endtask

  // sel 0: res_valid_o, 1: rready_o, 2: rready_o && rvalid_i. Returns at a negedge.
  task automatic wait_for(input int sel, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0: hit = res_valid_o;
        1: hit = rready_o;
        default: hit = rready_o && rvalid_i;
      endcase
    end
    if (!hit) begin
      compared++;
      mismatched++;
      $display("FAIL %s: got no event expected event within 40 cycles", name);
    end
  endtask

  task automatic check_counters(input string name);
    check({name, "_hit_cnt"},  128'(hit_cnt_o),  128'(exp_hit_cnt));
    check({name, "_miss_cnt"}, 128'(miss_cnt_o), 128'(exp_miss_cnt));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rden"},   128'(fifo_rden_o),      128'(0));
    check({name, "_rready"}, 128'(rready_o),         128'(0));
    check({name, "_valid"},  128'(res_valid_o),      128'(0));
    check({name, "_fields"}, 128'({res_hit_o, res_write_o, res_dirty_o, res_tid_o, res_victim_tag_o}), 128'(0));
    check({name, "_addr"},   128'(res_addr_o),       128'(0));
    check({name, "_cnts"},   128'({hit_cnt_o, miss_cnt_o}), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset values.
    #12;
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Hit from idle, with latency rden N -> res_valid N+3.
    issue(1'b0, ADDR_A, 16'h0007, 56'h80_0000_0000_0100, 1'b1, 1'b0, 34'h100);
    wait_results(1, "hit");
    check("latency", 128'(valid_rise_cyc - last_rden_cyc), 128'(3));
    tick();
    check_counters("hit");

    // Dirty miss on a write.
    issue(1'b1, ADDR_A, 16'h0008, 56'hC0_0000_0000_0101, 1'b0, 1'b1, 34'h101);
    wait_results(2, "dirty_miss");
    tick();
    check_counters("dirty_miss");

    // Invalid line with dirty bit set: miss, not dirty.
    issue(1'b0, ADDR_A, 16'h0009, 56'h40_0000_0000_0100, 1'b0, 1'b0, 34'h100);
    wait_results(3, "invalid");
    tick();
    check_counters("invalid");

    // Back-to-back throughput: all-ones tag hit, stored tag with bit 34 set
    // (miss despite matching low bits), tag zero with index/offset all ones.
    base = n_results;
    issue(1'b1, 64'hFFFF_FFFF_C000_0000, 16'hFFFF, 56'hC0_0003_FFFF_FFFF, 1'b1, 1'b1, 34'h3_FFFF_FFFF);
    issue(1'b0, ADDR_A,                  16'h0020, 56'h80_0004_0000_0100, 1'b0, 1'b0, 34'h100);
    issue(1'b0, 64'h0000_0000_3FFF_FFFF, 16'h0021, 56'h80_0000_0000_0000, 1'b1, 1'b0, 34'h0);
    wait_results(base + 3, "throughput");
    if (res_cyc_q.size() >= base + 3) begin
      check("throughput_gap1", 128'(res_cyc_q[base+1] - res_cyc_q[base]),   128'(3));
      check("throughput_gap2", 128'(res_cyc_q[base+2] - res_cyc_q[base+1]), 128'(3));
    end
    tick();
    check_counters("throughput");

    // Backpressure with a second entry waiting in the FIFO.
    res_ready_i = 1'b0;
    base = n_results;
    issue(1'b0, ADDR_A, 16'h0010, 56'h80_0000_0000_0100, 1'b1, 1'b0, 34'h100);
    issue(1'b1, ADDR_A, 16'h0011, 56'hC0_0000_0000_0200, 1'b0, 1'b1, 34'h200);
    wait_for(0, "bp_valid");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_valid",  128'(res_valid_o), 128'(1));
      check("bp_tid",    128'(res_tid_o),   128'(16'h0010));
      check("bp_addr",   128'(res_addr_o),  128'(ADDR_A));
      check("bp_hit",    128'(res_hit_o),   128'(1));
      check("bp_rden",   128'(fifo_rden_o), 128'(0));
      check("bp_rready", 128'(rready_o),    128'(0));
    end
    tick();
    res_ready_i = 1'b1;
    @(negedge clk);
    check("bp_chain_rden", 128'(fifo_rden_o), 128'(1));
    wait_results(base + 2, "backpressure");
    tick();
    check_counters("backpressure");

    // Empty FIFO, late response held high for 4 cycles.
    rsp_manual = 1'b1;
    rvalid_i   = 1'b0;
    base = n_results;
    issue(1'b0, ADDR_A, 16'h0012, 56'h0, 1'b1, 1'b0, 34'h100);
    wait_for(1, "late_wait_tag");
    repeat (2) begin
      @(negedge clk);
      check("late_rready", 128'(rready_o),    128'(1));
      check("late_rden",   128'(fifo_rden_o), 128'(0));
    end
    tick();
    rvalid_i = 1'b1;
    rtag_i   = 56'h80_0000_0000_0100;
    repeat (4) tick();
    rvalid_i = 1'b0;
    rtag_i   = '0;
    repeat (6) tick();
    check("late_one_result", 128'(n_results - base), 128'(1));
    check_counters("late");

    // Reset asserted in WAIT_TAG discards the in-flight entry.
    push_fifo(1'b1, 64'h1234_5678_9ABC_DEC0, 16'h0BAD);
    wait_for(1, "rst_wait_tag");
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_hit_cnt  = '0;
    exp_miss_cnt = '0;
    tick();
    rst_n = 1'b1;
    base = n_results;
    repeat (6) tick();
    check("midrst_no_replay", 128'(n_results - base), 128'(0));
    check("midrst_idle_rready", 128'(rready_o), 128'(0));
    rsp_manual = 1'b0;

    // Hit counter saturation.
    force dut.hit_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.hit_cnt_q;
    tick();
    check("sat_preload", 128'(hit_cnt_o), 128'(32'hFFFF_FFFF));
    exp_hit_cnt = 32'hFFFF_FFFF;
    base = n_results;
    issue(1'b0, ADDR_A, 16'h0030, 56'h80_0000_0000_0100, 1'b1, 1'b0, 34'h100);
    wait_results(base + 1, "saturate");
    tick();
    check_counters("saturate");

    // Clear coincident with a miss increment: clear wins.
    base = n_results;
    issue(1'b0, ADDR_A, 16'h0031, 56'h80_0000_0000_0777, 1'b0, 1'b0, 34'h777);
    wait_for(2, "clr_accept");
    stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    exp_hit_cnt  = '0;
    exp_miss_cnt = '0;
    wait_results(base + 1, "clear");
    tick();
    check_counters("clear");
    check("sb_drained", 128'(sb_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tag_compare.md
# tag_compare

Downstream stage of the tag FIFO. Pops one request entry at a time, pairs it with the in-order tag-read response returned by the memory controller, and decides hit or miss. Presents the result plus the stored line state on a valid/ready result channel toward the hit/miss handling logic, and keeps saturating hit and miss counters.

## Interface
- ADDR_WIDTH, 64, request address width
- TID_WIDTH, 16, transaction ID width
- INDEX_WIDTH, 24, cache set index width
- OFFSET_WIDTH, 6, line offset width (64 B lines)
- Derived: TAG_W = ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH (34 by default); must be ≤ 54

- clk  in  1  single clock
- rst_n  in  1  reset; asynchronous, active-low
- fifo_aempty_i  in  1  tag FIFO has no entry to read
- fifo_rden_o  out  1  tag FIFO read enable (one-cycle pulse)
- fifo_data_i  in  ADDR_WIDTH+TID_WIDTH+1  entry {is_write, addr, tid}; valid cycle after rden
- rtag_i  in  56  tag response {valid[55], dirty[54], stored_tag[53:0]}
- rvalid_i  in  1  tag response valid
- rready_o  out  1  tag response accept
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result accept
- res_hit_o  out  1  hit
- res_write_o  out  1  request was a write
- res_dirty_o  out  1  stored line valid and dirty
- res_addr_o  out  ADDR_WIDTH  request address
- res_tid_o  out  TID_WIDTH  request ID
- res_victim_tag_o  out  TAG_W  stored tag (low TAG_W bits of rtag_i[53:0])
- stat_clr_i  in  1  synchronous clear of counters
- hit_cnt_o  out  32  hits counted
- miss_cnt_o  out  32  misses counted

## Operation
- Memory controller returns tag responses in request issue order; one response per FIFO entry.
- FSM states: IDLE, FETCH, WAIT_TAG, OUT. One request in flight.
- IDLE: fifo_rden_o = !fifo_aempty_i; if asserted, go FETCH.
- FETCH: latch fifo_data_i into is_write/addr/tid registers; go WAIT_TAG.
- WAIT_TAG: rready_o = 1. On rvalid_i: req_tag = addr[ADDR_WIDTH-1:OFFSET_WIDTH+INDEX_WIDTH], zero-extended to 54 bits; hit = rtag_i[55] && (rtag_i[53:0] == req_tag); dirty = rtag_i[55] & rtag_i[54]; register all result fields; go OUT.
- OUT: res_valid_o = 1, fields stable until res_valid_o && res_ready_i. On handshake: if !fifo_aempty_i assert fifo_rden_o same cycle and go FETCH, else IDLE.
- Counters: on the WAIT_TAG rvalid_i cycle, hit_cnt_o or miss_cnt_o increments by 1, saturating at 0xFFFF_FFFF. stat_clr_i zeroes both and wins over a same-cycle increment.
- rready_o is 0 outside WAIT_TAG; responses arriving early are held by the producer.
- Invalid stored line (rtag_i[55]=0) is always a miss, res_dirty_o = 0.

## Timing
- Reset values: state IDLE; fifo_rden_o 0; rready_o 0; res_valid_o 0; all res_* fields 0; counters 0.
- Reset mid-operation discards the in-flight entry and result; no replay.
- fifo_rden_o, rready_o, res_valid_o are decoded from registered state (fifo_rden_o also from fifo_aempty_i and res_ready_i); no other combinational input-to-output paths.
- Latency: FIFO rden cycle N, entry latched N+1, response accepted at earliest N+2, res_valid_o at N+3.
- Throughput with zero-wait response and res_ready_i tied 1: one result per 3 cycles.
- fifo_rden_o never asserted when fifo_aempty_i = 1.

## Test plan
- Hit: entry {0, 64'h0000_0040_1234_5680, 16'h0007}, rtag_i = 56'h80_0000_0000_0100 -> res_hit_o=1, res_dirty_o=0, res_tid_o=16'h0007, hit_cnt_o=1.
- Dirty miss: same entry with is_write=1, rtag_i = 56'hC0_0000_0000_0101 -> res_hit_o=0, res_dirty_o=1, res_write_o=1, res_victim_tag_o=34'h101, miss_cnt_o=1.
- Invalid line: rtag_i = 56'h40_0000_0000_0100 -> miss, res_dirty_o=0.
- Backpressure: res_ready_i low 5 cycles -> res_valid_o and fields stable, no fifo_rden_o, rready_o=0; on ready, next FIFO entry read same cycle.
- FIFO empty then late response: fifo_aempty_i=1 -> fifo_rden_o stays 0; rvalid_i held 4 cycles in WAIT_TAG -> exactly one result, one counter increment.
- Reset asserted in WAIT_TAG, and hit_cnt_o preloaded to 0xFFFF_FFFF then hit -> outputs return to reset values; counter stays 0xFFFF_FFFF; stat_clr_i with increment -> 0.
